prim_timer_ctrl: RTL and testbench

Programmable timer controller that sequences a saturating step counter through load, prescaled counting and expiry, in one-shot or periodic mode. It sits between a register/config interface and the interrupt logic of the peripheral subsystem. It latches a configuration on start, generates prescaled count ticks, detects terminal count and raises a sticky interrupt with overrun tracking.

---
 rtl/prim_timer_ctrl.sv | 152 +++++++++++++++
 tb/tb_prim_timer_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prim_timer_ctrl.sv
// Programmable timer controller: latches a configuration on start, prescales
// count ticks, steps a saturating counter and flags expiry via done/irq/ovr.
module prim_timer_ctrl #(
  parameter int Width    = 8,
  parameter int PreWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                periodic_i,
  input  logic                up_i,
  input  logic [Width-1:0]    step_i,
  input  logic [Width-1:0]    limit_i,
  input  logic [PreWidth-1:0] prescale_i,
  input  logic                irq_clr_i,
  output logic                busy_o,
  output logic                tick_o,
  output logic [Width-1:0]    cnt_o,
  output logic                done_o,
  output logic                irq_o,
  output logic                ovr_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic                periodic_reg, periodic_next;
  logic                up_reg, up_next;
  logic [Width-1:0]    step_reg, step_next;
  logic [Width-1:0]    limit_reg, limit_next;
  logic [PreWidth-1:0] prescale_reg, prescale_next;
  logic [PreWidth-1:0] pre_reg, pre_next;
  logic [Width-1:0]    cnt_reg, cnt_next;
  logic                done_reg, done_next;
  logic                irq_reg, irq_next;
  logic                ovr_reg, ovr_next;

  logic                tick;
  logic                at_term;
  logic                expiry;
  logic [Width-1:0]    start_val;
  logic [Width:0]      sum;

  assign start_val = up_reg ? '0 : limit_reg;
  assign tick      = (state_reg == StRun) && (pre_reg == prescale_reg);
  assign at_term   = up_reg ? (cnt_reg == limit_reg) : (cnt_reg == '0);
  assign expiry    = tick && at_term && !stop_i;
  // One extra bit so the up-count saturates instead of wrapping.
  assign sum       = {1'b0, cnt_reg} + {1'b0, step_reg};

  always_comb begin
    state_next    = state_reg;
    periodic_next = periodic_reg;
    up_next       = up_reg;
    step_next     = step_reg;
    limit_next    = limit_reg;
    prescale_next = prescale_reg;
    pre_next      = pre_reg;
    cnt_next      = cnt_reg;

    case (state_reg)
      StIdle: begin
        if (start_i && !stop_i) begin
          state_next    = StLoad;
          periodic_next = periodic_i;
          up_next       = up_i;
          step_next     = (step_i == '0) ? Width'(1) : step_i;
          limit_next    = limit_i;
          prescale_next = prescale_i;
          // Start value is already visible during the LOAD cycle.
          cnt_next      = up_i ? '0 : limit_i;
        end
      end
      StLoad: begin
        if (stop_i) begin
          state_next = StIdle;
        end else begin
          state_next = StRun;
          cnt_next   = start_val;
          pre_next   = '0;
        end
      end
      StRun: begin
        if (stop_i) begin
          state_next = StIdle;
        end else begin
          pre_next = tick ? '0 : pre_reg + PreWidth'(1);
          if (tick) begin
            if (at_term) begin
              if (periodic_reg) begin
                cnt_next = start_val;
              end else begin
                state_next = StIdle;
              end
            end else if (up_reg) begin
              cnt_next = (sum > {1'b0, limit_reg}) ? limit_reg : sum[Width-1:0];
            end else begin
              cnt_next = (cnt_reg < step_reg) ? '0 : cnt_reg - step_reg;
            end
          end
        end
      end
      default: state_next = StIdle;
    endcase
  end

  // A clear coinciding with an expiry keeps irq set but still clears ovr.
  always_comb begin
    done_next = expiry;
    irq_next  = expiry ? 1'b1 : (irq_clr_i ? 1'b0 : irq_reg);
    ovr_next  = irq_clr_i ? 1'b0 : ((expiry && irq_reg) ? 1'b1 : ovr_reg);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= StIdle;
      periodic_reg <= 1'b0;
      up_reg       <= 1'b0;
      step_reg     <= '0;
      limit_reg    <= '0;
      prescale_reg <= '0;
      pre_reg      <= '0;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      irq_reg      <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      periodic_reg <= periodic_next;
      up_reg       <= up_next;
      step_reg     <= step_next;
      limit_reg    <= limit_next;
      prescale_reg <= prescale_next;
      pre_reg      <= pre_next;
      cnt_reg      <= cnt_next;
      done_reg     <= done_next;
      irq_reg      <= irq_next;
      ovr_reg      <= ovr_next;
    end
  end

  assign busy_o = (state_reg == StLoad) || (state_reg == StRun);
  assign tick_o = tick;
  assign cnt_o  = cnt_reg;
  assign done_o = done_reg;
  assign irq_o  = irq_reg;
  assign ovr_o  = ovr_reg;

endmodule

// File: tb/tb_prim_timer_ctrl.sv
// Randomized bench for prim_timer_ctrl against a tick-index reference model.
module tb_prim_timer_ctrl;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, periodic, up, clr;
  logic [W-1:0]  step, limit;
  logic [PW-1:0] prescale;
  logic          busy, tick, done, irq, ovr;
  logic [W-1:0]  cnt;

  prim_timer_ctrl #(.Width(W), .PreWidth(PW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .stop_i     (stop),
    .periodic_i (periodic),
    .up_i       (up),
    .step_i     (step),
    .limit_i    (limit),
    .prescale_i (prescale),
    .irq_clr_i  (clr),
    .busy_o     (busy),
    .tick_o     (tick),
    .cnt_o      (cnt),
    .done_o     (done),
    .irq_o      (irq),
    .ovr_o      (ovr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 run. The count is derived from the number
  // of ticks taken in the current period rather than stepped incrementally.
  int m_phase, m_per, m_up, m_step, m_limit, m_pre;
  int m_n, m_rc, m_cnt, m_done, m_irq, m_ovr;

  function automatic int val(input int n);
    int v;
    if (m_up != 0) begin
      v = n * m_step;
      return (v > m_limit) ? m_limit : v;
    end
    v = m_limit - n * m_step;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int ticks_to_term();
    return (m_limit + m_step - 1) / m_step;
  endfunction

  function automatic int m_tick();
    return (m_phase == 2 && (m_rc % (m_pre + 1)) == m_pre) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_per = 0; m_up = 0; m_step = 1; m_limit = 0; m_pre = 0;
    m_n = 0; m_rc = 0; m_cnt = 0; m_done = 0; m_irq = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    int tk, ex, irq_n, ovr_n;
    tk    = m_tick();
    ex    = (tk != 0 && m_n == ticks_to_term() && !stop) ? 1 : 0;
    irq_n = ex ? 1 : (clr ? 0 : m_irq);
    ovr_n = clr ? 0 : ((ex != 0 && m_irq != 0) ? 1 : m_ovr);
    m_done = ex;
    case (m_phase)
      0: if (start && !stop) begin
        m_per   = periodic;
        m_up    = up;
        m_step  = (step == 0) ? 1 : int'(step);
        m_limit = limit;
        m_pre   = prescale;
        m_cnt   = val(0);
        m_phase = 1;
      end
      1: if (stop) m_phase = 0;
         else begin
           m_phase = 2; m_rc = 0; m_n = 0; m_cnt = val(0);
         end
      default: if (stop) m_phase = 0;
         else begin
           if (tk != 0) begin
             if (m_n == ticks_to_term()) begin
               if (m_per != 0) begin m_n = 0; m_cnt = val(0); end
               else m_phase = 0;
             end else begin
               m_n++;
               m_cnt = val(m_n);
             end
           end
           m_rc++;
         end
    endcase
    m_irq = irq_n;
    m_ovr = ovr_n;
  endtask

  task automatic compare_all(input string pfx);
    check_eq({pfx, "busy"}, busy, (m_phase != 0) ? 1 : 0);
    check_eq({pfx, "tick"}, tick, m_tick());
    check_eq({pfx, "cnt"},  cnt,  m_cnt);
    check_eq({pfx, "done"}, done, m_done);
    check_eq({pfx, "irq"},  irq,  m_irq);
    check_eq({pfx, "ovr"},  ovr,  m_ovr);
  endtask

  // Directed configurations first, then random episodes.
  localparam int NDIR = 6;
  int d_lim [NDIR] = '{3, 5, 7, 7, 0, 1};
  int d_stp [NDIR] = '{1, 2, 3, 0, 4, 1};
  int d_pre [NDIR] = '{0, 1, 0, 2, 1, 0};
  int d_up  [NDIR] = '{1, 0, 1, 1, 0, 1};
  int d_per [NDIR] = '{0, 1, 0, 1, 1, 1};

  initial begin
    int noise, rst_at, expiries;
    rst_n = 1'b0; start = 0; stop = 0; periodic = 0; up = 0; clr = 0;
    step = '0; limit = '0; prescale = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset_");
    rst_n = 1'b1;

    for (int e = 0; e < 70; e++) begin
      noise    = (e >= NDIR) ? 1 : 0;
      rst_at   = (noise != 0 && e % 9 == 0) ? 10 + $urandom_range(0, 39) : -1;
      expiries = 0;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        compare_all("");
        expiries += m_done;
        if (c == rst_at) begin
          rst_n = 1'b0;
          #1;
          model_reset();
          compare_all("async_rst_");
          @(negedge clk);
          rst_n = 1'b1;
          compare_all("post_rst_");
        end
        start = 0; stop = 0; clr = 0;
        if (c == 0) begin
          stop = 1;
        end else if (c == 1) begin
          start = 1;
          if (noise == 0) begin
            limit = d_lim[e]; step = d_stp[e]; prescale = d_pre[e];
            up = d_up[e][0]; periodic = d_per[e][0];
          end else begin
            limit    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 11);
            step     = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 3);
            prescale = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            up       = $urandom_range(0, 1);
            periodic = $urandom_range(0, 1);
          end
        end else begin
          clr = (c % 9 == 8) ? 1'b1 : 1'b0;
          // Config inputs wander after start; they must not affect the run.
          limit = $urandom_range(0, 255);
          step  = $urandom_range(0, 255);
          if (noise != 0) begin
            start    = ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
            stop     = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
            clr      = ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0;
            prescale = $urandom_range(0, 3);
            up       = $urandom_range(0, 1);
            periodic = $urandom_range(0, 1);
          end
        end
        model_step();
      end
      $display("episode %0d: up=%0d periodic=%0d limit=%0d step=%0d prescale=%0d expiries=%0d",
               e, m_up, m_per, m_limit, m_step, m_pre, expiries);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
